wave_mixer: RTL

// - Successor to the combinational channel summer.
// - Mixes NUM unsigned N-bit channel samples into one OUT_W-bit audio sample.

---
 rtl/wave_mixer_pkg.sv | 19 +
 rtl/wave_gain.sv | 18 +
 rtl/wave_mixer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wave_mixer_pkg.sv
// Shared types and helpers for the wave mixer.
// The accumulator width covers NUM full-scale products without wrapping.
package wave_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  function automatic int acc_width(
    input int n,
    input int g,
    input int num
  );
    return n + g + $clog2(num);
  endfunction

endpackage

// File: rtl/wave_gain.sv
// One channel's contribution: sample times gain, rescaled so that
// 2**(GAIN_W-1) is unity, then forced to zero when muted.
module wave_gain #(
  parameter int N      = 8,
  parameter int GAIN_W = 4
) (
  input  logic [N-1:0]        i_ch,
  input  logic [GAIN_W-1:0]   i_gain,
  input  logic                i_mute,
  output logic [N+GAIN_W-1:0] o_contrib
);

  logic [N+GAIN_W-1:0] w_prod;

  assign w_prod    = (N+GAIN_W)'(i_ch) * (N+GAIN_W)'(i_gain);
  assign o_contrib = i_mute ? '0 : (w_prod >> (GAIN_W - 1));

endmodule

// File: rtl/wave_mixer.sv
// Sequential channel mixer: one gain multiply per clock into a wide
// accumulator, saturated to OUT_W bits when the last channel is added.
module wave_mixer
  import wave_mixer_pkg::*;
#(
  parameter int NUM    = 4,
  parameter int N      = 8,
  parameter int GAIN_W = 4,
  parameter int OUT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [N*NUM-1:0]        channels,
  input  logic [GAIN_W*NUM-1:0]   gains,
  input  logic [NUM-1:0]          mute,
  input  logic                    overrun_clr,
  output logic                    ready,
  output logic [OUT_W-1:0]        audio,
  output logic                    audio_valid,
  output logic                    clipped,
  output logic                    overrun
);

  localparam int ACC_W = acc_width(N, GAIN_W, NUM);
  localparam int IDX_W = $clog2(NUM);
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM - 1);

  state_t r_state;
  state_t w_next;

  logic [N-1:0]      r_ch   [NUM];
  logic [GAIN_W-1:0] r_gain [NUM];
  logic [NUM-1:0]    r_mute;

  logic [IDX_W-1:0] r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0] r_audio;
  logic             r_clip;
  logic             r_ovr;

  logic [N+GAIN_W-1:0] w_contrib;
  logic [ACC_W-1:0]    w_sum;
  logic [CMP_W-1:0]    w_sum_x;
  logic                w_clip;
  logic                w_last;
  logic                w_accept;

  wave_gain #(
    .N      (N),
    .GAIN_W (GAIN_W)
  ) u_gain (
    .i_ch      (r_ch[r_idx]),
    .i_gain    (r_gain[r_idx]),
    .i_mute    (r_mute[r_idx]),
    .o_contrib (w_contrib)
  );

  assign w_accept = (r_state == IDLE) && sample_valid;
  assign w_last   = (r_idx == LAST);
  assign w_sum    = r_acc + ACC_W'(w_contrib);
  assign w_sum_x  = CMP_W'(w_sum);
  assign w_clip   = w_sum_x > CMP_W'({OUT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (sample_valid) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Snapshot lets the channel bus move on right after the accept cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM; i++) begin
        r_ch[i]   <= channels[N*i +: N];
        r_gain[i] <= gains[GAIN_W*i +: GAIN_W];
      end
      r_mute <= mute;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_acc   <= '0;
      r_audio <= '0;
      r_clip  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= '0;
        r_idx <= '0;
      end
      if (r_state == ACCUM) begin
        r_acc <= w_sum;
        if (!w_last) r_idx <= r_idx + 1'b1;
      end
      // Output lands on the final add so it is visible during DONE
      if ((r_state == ACCUM) && w_last) begin
        r_audio <= w_clip ? '1 : w_sum_x[OUT_W-1:0];
        r_clip  <= w_clip;
      end
      if (sample_valid && (r_state != IDLE)) r_ovr <= 1'b1;
      else if (overrun_clr)                  r_ovr <= 1'b0;
    end
  end

  assign ready       = (r_state == IDLE);
  assign audio_valid = (r_state == DONE);
  assign audio       = r_audio;
  assign clipped     = r_clip;
  assign overrun     = r_ovr;

endmodule
